stage_sequencer: RTL and testbench
==================================

// Module: stage_sequencer
// PURPOSE
//  Top-level game flow controller. Generates the 4-bit stage code consumed by the
//  main character, enemy and renderer blocks: 0=title, 1..NUM_LEVELS=level, E=win,
//  F=game over. Sequences title -> intro -> play -> clear -> next level.
//  Ends the game on lives exhaustion or per-level time-out.
// PARAMETERS
//  NUM_LEVELS     3          last playable level (1..13)
//  INTRO_CYCLES   100        cycles a level is shown frozen before play
//  CLEAR_CYCLES   100        cycles the frozen "cleared" hold lasts before advancing
//  TIME_LIMIT     60         seconds allowed per level (1..255)
//  TICKS_PER_SEC  100        clk cycles per timer second
// PORTS
//  clk           in   1  system clock (game tick)
//  rst           in   1  asynchronous reset, active-low
//  ENTER_signal  in   1  start/continue key, level-sensitive; rising edge used internally
//  lives         in   4  main character lives
//  level_clear   in   1  all enemies of current level dead (level-sensitive)
//  stage         out  4  current stage code
//  freeze        out  1  1 = enemies/projectiles must hold still
//  time_left     out  8  seconds remaining in current level
//  level_start   out  1  one-cycle pulse on INTRO->PLAY
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset (rst=0): state=TITLE, stage=0, freeze=1, time_left=0, level_start=0,
//    level=1, prescaler=0, hold counter=0, ENTER edge register=0.
//  - Outputs are registered: a decision taken on cycle N is visible on N+1.
//  - ENTER edge: start_edge = ENTER_signal & ~enter_q. Holding the key does not
//    retrigger.
//  - States / stage / freeze:
//    TITLE    0      1  start_edge -> INTRO, level=1
//    INTRO    level  1  hold=INTRO_CYCLES-1 down to 0, then -> PLAY,
//                       level_start=1 for one cycle
//    PLAY     level  0  see priority list below
//    CLEARED  level  1  hold CLEAR_CYCLES; at end: level==NUM_LEVELS -> WIN,
//                       else level+1 -> INTRO
//    WIN      E      1  start_edge -> TITLE
//    LOSE     F      1  start_edge -> TITLE
//  - PLAY priority (same-cycle events): lives==0 -> LOSE; else timer expiry
//    (time_left==0) -> LOSE; else level_clear -> CLEARED. Losing wins ties.
//  - Timer: entering INTRO loads time_left=TIME_LIMIT and clears the prescaler.
//    In PLAY the prescaler counts 0..TICKS_PER_SEC-1. On wrap, time_left
//    decrements and saturates at 0 (no wrap to 255). time_left is frozen in
//    all other states.
//  - The 0-second check uses the registered time_left: LOSE is entered the
//    cycle after time_left reads 0.
//  - start_edge is ignored in INTRO, PLAY and CLEARED. level_clear and lives
//    are ignored outside PLAY.
//  - level never exceeds NUM_LEVELS. It is only incremented on CLEARED->INTRO.
//  - Hold counter is loaded on state entry; INTRO/CLEARED last exactly
//    INTRO_CYCLES / CLEAR_CYCLES cycles.
//  - Reset asserted mid-level returns immediately (asynchronously) to the TITLE
//    outputs. Downstream blocks see stage=0 and restore lives/position.
// STRUCTURE
//  - Shared package/header: stage codes (STAGE_TITLE=4'h0, STAGE_WIN=4'hE,
//    STAGE_LOSE=4'hF) and the state encoding. The same codes are decoded by
//    the character and enemy blocks.
//  - One sub-module: sec_tick_gen (prescaler; inputs clk, rst, clr, en;
//    output tick, one-cycle pulse every TICKS_PER_SEC enabled cycles).
//  - FSM, hold counter, level register and timer live in stage_sequencer.
// TESTING  (bench params: NUM_LEVELS=2, INTRO=4, CLEAR=3, TIME_LIMIT=2, TICKS=5)
//  - Reset then ENTER held 20 cycles -> stage 0->1 once; freeze=1 for 4 cycles;
//    one level_start pulse; stage stays 1 with no retrigger.
//  - In PLAY pulse level_clear -> 3 frozen cycles at stage 1, then stage=2 with
//    time_left=2. Clear again -> stage=E; ENTER edge -> stage=0.
//  - In PLAY idle -> time_left 2->1->0 every 5 cycles; the cycle after reading
//    0, stage=F; time_left stays 0.
//  - level_clear and lives=0 in the same PLAY cycle -> stage=F, not CLEARED.
//  - lives=0 or level_clear during INTRO/CLEARED -> ignored. rst low mid-PLAY ->
//    outputs at reset values with no clock edge required.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// Shared stage codes and FSM state encoding for the game flow controller.
// The stage codes are also decoded by the character and enemy blocks.
package stage_sequencer_pkg;

  localparam logic [3:0] STAGE_TITLE = 4'h0;
  localparam logic [3:0] STAGE_WIN   = 4'hE;
  localparam logic [3:0] STAGE_LOSE  = 4'hF;

  typedef logic [2:0] state_t;

  localparam state_t StTitle   = 3'd0;
  localparam state_t StIntro   = 3'd1;
  localparam state_t StPlay    = 3'd2;
  localparam state_t StCleared = 3'd3;
  localparam state_t StWin     = 3'd4;
  localparam state_t StLose    = 3'd5;

endpackage

// File: rtl/stage_sequencer_if.sv
// Player-input and stage-status bundle between the game flow controller and the rest of the game.
interface stage_sequencer_if;

  logic       ENTER_signal;
  logic [3:0] lives;
  logic       level_clear;
  logic [3:0] stage;
  logic       freeze;
  logic [7:0] time_left;
  logic       level_start;

  modport master (
    output ENTER_signal, lives, level_clear,
    input  stage, freeze, time_left, level_start
  );

  modport slave (
    input  ENTER_signal, lives, level_clear,
    output stage, freeze, time_left, level_start
  );

endinterface

// File: rtl/stage_sequencer_sec_tick_gen.sv
// Seconds prescaler: one-cycle tick after every TICKS_PER_SEC enabled cycles.
module sec_tick_gen #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICKS_PER_SEC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wrap;

  assign wrap = (cnt_q == CntMax);
  assign tick = en && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Game flow controller: title -> intro -> play -> cleared -> next level, ending in win or
// game over. Owns the FSM, hold counter, level register and per-level countdown timer.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LEVELS    = 3,
  parameter int unsigned INTRO_CYCLES  = 100,
  parameter int unsigned CLEAR_CYCLES  = 100,
  parameter int unsigned TIME_LIMIT    = 60,
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic              clk,
  input  logic              rst,
  stage_sequencer_if.slave  bus
);

  state_t      state_q, state_d;
  logic [3:0]  level_q, level_d;
  logic [15:0] hold_q, hold_d;
  logic [7:0]  time_q, time_d;
  logic        enter_q;
  logic        level_start_q, level_start_d;
  logic        start_edge;
  logic        tick;
  logic        presc_clr;

  assign start_edge = bus.ENTER_signal & ~enter_q;

  sec_tick_gen #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_sec_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (state_q == StPlay),
    .tick (tick)
  );

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    hold_d        = hold_q;
    time_d        = time_q;
    level_start_d = 1'b0;
    presc_clr     = 1'b0;
    case (state_q)
      StTitle: begin
        if (start_edge) begin
          state_d   = StIntro;
          level_d   = 4'd1;
          hold_d    = 16'(INTRO_CYCLES - 1);
          time_d    = 8'(TIME_LIMIT);
          presc_clr = 1'b1;
        end
      end
      StIntro: begin
        if (hold_q == '0) begin
          state_d       = StPlay;
          level_start_d = 1'b1;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      StPlay: begin
        if (tick && time_q != 8'd0) time_d = time_q - 8'd1;
        // Losing takes priority over clearing in the same cycle.
        if (bus.lives == 4'd0 || time_q == 8'd0) begin
          state_d = StLose;
        end else if (bus.level_clear) begin
          state_d = StCleared;
          hold_d  = 16'(CLEAR_CYCLES - 1);
        end
      end
      StCleared: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 16'd1;
        end else if (level_q == 4'(NUM_LEVELS)) begin
          state_d = StWin;
        end else begin
          state_d   = StIntro;
          level_d   = level_q + 4'd1;
          hold_d    = 16'(INTRO_CYCLES - 1);
          time_d    = 8'(TIME_LIMIT);
          presc_clr = 1'b1;
        end
      end
      StWin, StLose: begin
        if (start_edge) state_d = StTitle;
      end
      default: state_d = StTitle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StTitle;
      level_q       <= 4'd1;
      hold_q        <= '0;
      time_q        <= '0;
      enter_q       <= 1'b0;
      level_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      hold_q        <= hold_d;
      time_q        <= time_d;
      enter_q       <= bus.ENTER_signal;
      level_start_q <= level_start_d;
    end
  end

  always_comb begin
    case (state_q)
      StIntro, StPlay, StCleared: bus.stage = level_q;
      StWin:                      bus.stage = STAGE_WIN;
      StLose:                     bus.stage = STAGE_LOSE;
      default:                    bus.stage = STAGE_TITLE;
    endcase
  end

  assign bus.freeze      = (state_q != StPlay);
  assign bus.time_left   = time_q;
  assign bus.level_start = level_start_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with small parameters so every phase is a few cycles long.
module tb_stage_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [7:0] exp_stage, exp_tl;
  logic       exp_fr, exp_ls;

  stage_sequencer_if bus ();

  stage_sequencer #(
    .NUM_LEVELS    (2),
    .INTRO_CYCLES  (4),
    .CLEAR_CYCLES  (3),
    .TIME_LIMIT    (2),
    .TICKS_PER_SEC (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.ENTER_signal = 1'b0;
    bus.lives        = 4'd3;
    bus.level_clear  = 1'b0;
    #2;
    chk("rst_stage", bus.stage, 8'h0);
    chk("rst_freeze", bus.freeze, 8'h1);
    chk("rst_time", bus.time_left, 8'h0);
    chk("rst_lstart", bus.level_start, 8'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("title_idle", bus.stage, 8'h0);

    // ENTER held 20 cycles: one start, intro, play, time-out, no retrigger while held.
    bus.ENTER_signal = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      exp_stage = (i <= 15) ? 8'h1 : 8'hF;
      exp_tl    = (i <= 9) ? 8'd2 : (i <= 14) ? 8'd1 : 8'd0;
      exp_fr    = !(i >= 5 && i <= 15);
      exp_ls    = (i == 5);
      chk($sformatf("hold_stage_%0d", i), bus.stage, exp_stage);
      chk($sformatf("hold_time_%0d", i), bus.time_left, exp_tl);
      chk($sformatf("hold_freeze_%0d", i), bus.freeze, exp_fr);
      chk($sformatf("hold_lstart_%0d", i), bus.level_start, exp_ls);
    end
    bus.ENTER_signal = 1'b0;
    cyc();
    chk("lose_stays", bus.stage, 8'hF);
    bus.ENTER_signal = 1'b1;
    cyc();
    chk("lose_to_title", bus.stage, 8'h0);

    // Full win through two levels; lives/level_clear ignored outside PLAY.
    bus.ENTER_signal = 1'b0;
    cyc();
    bus.ENTER_signal = 1'b1;
    cyc();
    chk("start_b", bus.stage, 8'h1);
    bus.ENTER_signal = 1'b0;
    bus.lives        = 4'd0;
    bus.level_clear  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("intro_ignore_stage", bus.stage, 8'h1);
      chk("intro_ignore_freeze", bus.freeze, 8'h1);
    end
    bus.lives       = 4'd3;
    bus.level_clear = 1'b0;
    cyc();
    chk("play_b_freeze", bus.freeze, 8'h0);
    chk("play_b_lstart", bus.level_start, 8'h1);
    bus.level_clear = 1'b1;
    cyc();
    chk("clear1_stage", bus.stage, 8'h1);
    chk("clear1_freeze", bus.freeze, 8'h1);
    bus.level_clear = 1'b0;
    bus.lives       = 4'd0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("clear1_hold_stage", bus.stage, 8'h1);
      chk("clear1_hold_freeze", bus.freeze, 8'h1);
    end
    bus.lives = 4'd3;
    cyc();
    chk("lvl2_stage", bus.stage, 8'h2);
    chk("lvl2_time", bus.time_left, 8'd2);
    chk("lvl2_freeze", bus.freeze, 8'h1);
    repeat (3) cyc();
    chk("lvl2_intro_end", bus.freeze, 8'h1);
    cyc();
    chk("lvl2_play_freeze", bus.freeze, 8'h0);
    chk("lvl2_play_stage", bus.stage, 8'h2);
    bus.level_clear = 1'b1;
    cyc();
    bus.level_clear = 1'b0;
    chk("clear2_freeze", bus.freeze, 8'h1);
    repeat (2) cyc();
    chk("clear2_hold_stage", bus.stage, 8'h2);
    cyc();
    chk("win_stage", bus.stage, 8'hE);
    chk("win_freeze", bus.freeze, 8'h1);
    bus.ENTER_signal = 1'b1;
    cyc();
    chk("win_to_title", bus.stage, 8'h0);
    bus.ENTER_signal = 1'b0;
    cyc();

    // lives==0 and level_clear together in PLAY: loss wins.
    bus.ENTER_signal = 1'b1;
    cyc();
    chk("start_c_level1", bus.stage, 8'h1);
    bus.ENTER_signal = 1'b0;
    repeat (4) cyc();
    chk("play_c_freeze", bus.freeze, 8'h0);
    bus.lives       = 4'd0;
    bus.level_clear = 1'b1;
    cyc();
    chk("tie_stage", bus.stage, 8'hF);
    chk("tie_freeze", bus.freeze, 8'h1);
    bus.lives       = 4'd3;
    bus.level_clear = 1'b0;
    cyc();
    chk("tie_stays", bus.stage, 8'hF);

    // Asynchronous reset mid-PLAY.
    bus.ENTER_signal = 1'b1;
    cyc();
    chk("lose_to_title_d", bus.stage, 8'h0);
    bus.ENTER_signal = 1'b0;
    cyc();
    bus.ENTER_signal = 1'b1;
    cyc();
    bus.ENTER_signal = 1'b0;
    repeat (4) cyc();
    chk("play_d_lstart", bus.level_start, 8'h1);
    chk("play_d_time", bus.time_left, 8'd2);
    rst = 1'b0;
    #1;
    chk("arst_stage", bus.stage, 8'h0);
    chk("arst_freeze", bus.freeze, 8'h1);
    chk("arst_time", bus.time_left, 8'h0);
    chk("arst_lstart", bus.level_start, 8'h0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
